// File: rtl/buffer_read_scheduler_pkg.sv
// Shared sizing, latencies and the read-command record for the buffer read scheduler.
// Slot/module counts mirror the arithmetic-unit configuration they serve.
package buffer_read_scheduler_pkg;

    localparam int SLOT_NUM   = 20;
    localparam int MODULE_NUM = 20;
    localparam int ADDR_W     = 32;
    localparam int CNT_W      = 16;
    localparam int RAM_LAT    = 1;
    localparam int INTC_LAT   = 1;
    localparam int DLY_CYCLES = RAM_LAT + INTC_LAT;
    localparam int SLOT_W     = $clog2(SLOT_NUM);
    localparam int MOD_W      = $clog2(MODULE_NUM);

    typedef struct packed {
        logic [SLOT_W-1:0] slot;
        logic [MOD_W-1:0]  mod;
        logic [ADDR_W-1:0] base;
        logic [CNT_W-1:0]  count;
    } buffer_read_cmd_t;

    // Index fields are wider than the populated range, so encodings past the end exist.
    function automatic logic cmd_in_range(input buffer_read_cmd_t c);
        return (32'(c.slot) < 32'(SLOT_NUM)) && (32'(c.mod) < 32'(MODULE_NUM));
    endfunction

endpackage

// File: rtl/buffer_read_scheduler_slot_raddr_gen.sv
// Per-slot read-address generator: walks base..base+count-1, one address per cycle,
// and flags the cycle carrying the final address.
module slot_raddr_gen
    import buffer_read_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              last
);

    logic [CNT_W-1:0] rem;

    // start is only ever raised while idle and with a non-zero count.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
            rem  <= '0;
            busy <= 1'b0;
            last <= 1'b0;
        end else if (start) begin
            addr <= base;
            rem  <= count;
            busy <= 1'b1;
            last <= (count == CNT_W'(1));
        end else if (busy) begin
            if (last) begin
                // Address holds its final value after release.
                busy <= 1'b0;
                last <= 1'b0;
            end else begin
                addr <= addr + ADDR_W'(1);
                rem  <= rem - CNT_W'(1);
                last <= (rem == CNT_W'(2));
            end
        end
    end

endmodule

// File: rtl/buffer_read_scheduler.sv
// Schedules slot->module read transfers: steers the interconnect, generates per-slot
// RAM addresses and produces per-module valid/last aligned to the interconnect output.
module buffer_read_scheduler
    import buffer_read_scheduler_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   cmd_valid,
    output logic                                   cmd_ready,
    input  buffer_read_cmd_t                       cmd,
    output logic                                   cmd_err,
    output logic [MODULE_NUM-1:0][SLOT_W-1:0]      slot_select,
    output logic [SLOT_NUM-1:0][ADDR_W-1:0]        ram_raddr,
    output logic [MODULE_NUM-1:0]                  module_in_valid,
    output logic [MODULE_NUM-1:0]                  module_in_last,
    output logic                                   idle
);

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd must stay stable while cmd_valid is high and cmd_ready is low, and
    // cmd_ready depends only on rst, registered busy bits and the offered cmd.

    logic [SLOT_NUM-1:0]   slot_busy;
    logic [SLOT_NUM-1:0]   slot_last;
    logic [SLOT_NUM-1:0]   slot_start;
    logic [MODULE_NUM-1:0] mod_busy;
    logic [MODULE_NUM-1:0] mod_feed;
    logic [MODULE_NUM-1:0] beat_valid;
    logic [MODULE_NUM-1:0] beat_last;
    logic [MODULE_NUM-1:0] dly_valid [DLY_CYCLES];
    logic [MODULE_NUM-1:0] dly_last  [DLY_CYCLES];
    logic [MODULE_NUM-1:0] dly_any;
    logic                  in_range;
    logic                  accept;
    logic                  start_ok;

    assign in_range  = cmd_in_range(cmd);
    // Out-of-range commands are always ready so they cannot wedge the queue head.
    assign cmd_ready = !rst && (!in_range || (!slot_busy[cmd.slot] && !mod_busy[cmd.mod]));
    assign accept    = cmd_valid && cmd_ready;
    assign start_ok  = accept && in_range && (cmd.count != '0);

    for (genvar s = 0; s < SLOT_NUM; s++) begin : g_slot
        assign slot_start[s] = start_ok && (cmd.slot == SLOT_W'(s));

        slot_raddr_gen u_gen (
            .clk   (clk),
            .rst   (rst),
            .start (slot_start[s]),
            .base  (cmd.base),
            .count (cmd.count),
            .addr  (ram_raddr[s]),
            .busy  (slot_busy[s]),
            .last  (slot_last[s])
        );
    end

    // mod_feed tracks the address phase per module, so a slot reused by another
    // module while this one drains its delay line never aliases onto it.
    always_comb begin
        beat_valid = '0;
        beat_last  = '0;
        dly_any    = '0;
        for (int m = 0; m < MODULE_NUM; m++) begin
            beat_valid[m] = mod_feed[m];
            beat_last[m]  = mod_feed[m] && slot_last[slot_select[m]];
        end
        for (int k = 0; k < DLY_CYCLES; k++) begin
            dly_any = dly_any | dly_valid[k];
        end
    end

    assign module_in_valid = dly_valid[DLY_CYCLES-1];
    assign module_in_last  = dly_last[DLY_CYCLES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_select <= '0;
            mod_busy    <= '0;
            mod_feed    <= '0;
            cmd_err     <= 1'b0;
            idle        <= 1'b1;
            for (int k = 0; k < DLY_CYCLES; k++) begin
                dly_valid[k] <= '0;
                dly_last[k]  <= '0;
            end
        end else begin
            cmd_err <= accept && !in_range;
            idle    <= !(start_ok || (|slot_busy) || (|mod_busy) || (|dly_any));

            // Delay line models RAM read latency plus interconnect pipeline.
            dly_valid[0] <= beat_valid;
            dly_last[0]  <= beat_last;
            for (int k = 1; k < DLY_CYCLES; k++) begin
                dly_valid[k] <= dly_valid[k-1];
                dly_last[k]  <= dly_last[k-1];
            end

            mod_feed <= mod_feed & ~beat_last;
            mod_busy <= mod_busy & ~(module_in_valid & module_in_last);

            if (start_ok) begin
                slot_select[cmd.mod] <= cmd.slot;
                mod_busy[cmd.mod]    <= 1'b1;
                mod_feed[cmd.mod]    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_buffer_read_scheduler.sv
// Bench for buffer_read_scheduler: vector table plus hand sequences, with a
// scoreboard of expected addresses and beats keyed by the cycle they must appear.
module tb_buffer_read_scheduler;
    import buffer_read_scheduler_pkg::*;

    localparam int ADDR_OFS  = 1;
    localparam int VALID_OFS = 3;
    localparam int NV        = 7;

    logic                              clk = 1'b0;
    logic                              rst;
    logic                              cmd_valid;
    logic                              cmd_ready;
    buffer_read_cmd_t                  cmd;
    logic                              cmd_err;
    logic [MODULE_NUM-1:0][SLOT_W-1:0] slot_select;
    logic [SLOT_NUM-1:0][ADDR_W-1:0]   ram_raddr;
    logic [MODULE_NUM-1:0]             module_in_valid;
    logic [MODULE_NUM-1:0]             module_in_last;
    logic                              idle;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // {cycle, last} per module and {cycle, address} per slot
    logic [32:0] exp_q [MODULE_NUM][$];
    logic [63:0] exp_a_q [SLOT_NUM][$];

    typedef struct {
        logic [4:0]  slot;
        logic [4:0]  mod;
        logic [31:0] base;
        logic [15:0] count;
        logic        exp_err;
    } vec_t;

    vec_t vecs [NV];

    buffer_read_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd             (cmd),
        .cmd_err         (cmd_err),
        .slot_select     (slot_select),
        .ram_raddr       (ram_raddr),
        .module_in_valid (module_in_valid),
        .module_in_last  (module_in_last),
        .idle            (idle)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic queues_empty();
        for (int m = 0; m < MODULE_NUM; m++) if (exp_q[m].size() != 0) return 1'b0;
        for (int s = 0; s < SLOT_NUM; s++) if (exp_a_q[s].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic flush_queues();
        for (int m = 0; m < MODULE_NUM; m++) exp_q[m].delete();
        for (int s = 0; s < SLOT_NUM; s++) exp_a_q[s].delete();
    endtask

    // Monitor samples 4 time units after each rising edge, before the driver's falling edge.
    always @(posedge clk) begin
        logic [32:0] e;
        logic [63:0] a;
        #4;
        for (int m = 0; m < MODULE_NUM; m++) begin
            if (exp_q[m].size() != 0 && exp_q[m][0][32:1] < 32'(cyc)) begin
                e = exp_q[m].pop_front();
                checks++;
                errors++;
                $display("FAIL beat_missed module=%0d actual=none required_cycle=%0d", m, e[32:1]);
            end
            if (module_in_valid[m] === 1'b1) begin
                if (exp_q[m].size() == 0 || exp_q[m][0][32:1] != 32'(cyc)) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_spurious module=%0d cycle=%0d actual=valid required=idle", m, cyc);
                end else begin
                    e = exp_q[m].pop_front();
                    check($sformatf("beat_last_m%0d", m), 64'(module_in_last[m]), 64'(e[0]));
                end
            end else if (module_in_last[m] === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL last_without_valid module=%0d cycle=%0d actual=1 required=0", m, cyc);
            end
        end
        for (int s = 0; s < SLOT_NUM; s++) begin
            while (exp_a_q[s].size() != 0 && exp_a_q[s][0][63:32] <= 32'(cyc)) begin
                a = exp_a_q[s].pop_front();
                if (a[63:32] == 32'(cyc))
                    check($sformatf("raddr_s%0d", s), 64'(ram_raddr[s]), 64'(a[31:0]));
                else begin
                    checks++;
                    errors++;
                    $display("FAIL raddr_missed slot=%0d actual=none required=%0h", s, a[31:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [4:0] s, input logic [4:0] m, input logic [31:0] b,
                        input logic [15:0] c, output int acc, output int waited);
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd.slot   = s;
        cmd.mod    = m;
        cmd.base   = b;
        cmd.count  = c;
        #1;
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (cmd_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout slot=%0d module=%0d actual=blocked required=accepted", s, m);
            cmd_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc;
        if (s < 5'(SLOT_NUM) && m < 5'(MODULE_NUM)) begin
            for (int i = 0; i < int'(c); i++) begin
                exp_a_q[s].push_back({32'(acc + ADDR_OFS + i), b + 32'(i)});
                exp_q[m].push_back({32'(acc + VALID_OFS + i), (i == int'(c) - 1)});
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (!queues_empty() && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!queues_empty()) begin
            errors++;
            $display("FAIL drain_timeout actual=pending required=empty");
            flush_queues();
        end
        repeat (3) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc, acc2, waited, waited2;
        logic [31:0] last_a;
        logic        active;

        vecs[0] = '{slot: 5'd3,  mod: 5'd5,  base: 32'h0000_0100, count: 16'd4, exp_err: 1'b0};
        vecs[1] = '{slot: 5'd0,  mod: 5'd0,  base: 32'h0000_0000, count: 16'd1, exp_err: 1'b0};
        vecs[2] = '{slot: 5'd19, mod: 5'd19, base: 32'hFFFF_FFFE, count: 16'd4, exp_err: 1'b0};
        vecs[3] = '{slot: 5'd7,  mod: 5'd2,  base: 32'hABCD_0000, count: 16'd3, exp_err: 1'b0};
        vecs[4] = '{slot: 5'd25, mod: 5'd2,  base: 32'h0000_0000, count: 16'd4, exp_err: 1'b1};
        vecs[5] = '{slot: 5'd4,  mod: 5'd20, base: 32'h0000_0000, count: 16'd4, exp_err: 1'b1};
        vecs[6] = '{slot: 5'd6,  mod: 5'd6,  base: 32'h0000_0050, count: 16'd0, exp_err: 1'b0};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd       = '0;
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", 64'(cmd_ready), 64'd0);
        check("reset_idle", 64'(idle), 64'd1);
        check("reset_valid", 64'(module_in_valid), 64'd0);
        check("reset_cmd_err", 64'(cmd_err), 64'd0);
        check("reset_raddr3", 64'(ram_raddr[3]), 64'd0);
        check("reset_select5", 64'(slot_select[5]), 64'd0);
        rst = 1'b0;

        // Table-driven single commands, each drained before the next.
        for (int i = 0; i < NV; i++) begin
            send(vecs[i].slot, vecs[i].mod, vecs[i].base, vecs[i].count, acc, waited);
            check($sformatf("v%0d_accept_wait", i), 64'(waited), 64'd0);
            @(negedge clk);
            active = !vecs[i].exp_err && vecs[i].count != 16'd0;
            check($sformatf("v%0d_cmd_err", i), 64'(cmd_err), 64'(vecs[i].exp_err));
            check($sformatf("v%0d_idle_busy", i), 64'(idle), 64'(!active));
            if (active)
                check($sformatf("v%0d_slot_select", i), 64'(slot_select[vecs[i].mod]), 64'(vecs[i].slot));
            drain();
            check($sformatf("v%0d_idle_drained", i), 64'(idle), 64'd1);
            check($sformatf("v%0d_cmd_err_pulse", i), 64'(cmd_err), 64'd0);
            if (active) begin
                last_a = vecs[i].base + 32'(vecs[i].count) - 32'd1;
                check($sformatf("v%0d_raddr_hold", i), 64'(ram_raddr[vecs[i].slot]), 64'(last_a));
            end
        end

        // Same slot back-to-back: second waits for slot release.
        send(5'd3, 5'd5, 32'h400, 16'd8, acc, waited);
        send(5'd3, 5'd7, 32'h500, 16'd2, acc2, waited2);
        check("slot_stall_accept", 64'(acc2 - acc), 64'd9);
        drain();

        // Same module back-to-back: second waits for the last beat to leave.
        send(5'd8, 5'd9, 32'h0, 16'd2, acc, waited);
        send(5'd10, 5'd9, 32'h20, 16'd1, acc2, waited2);
        check("module_stall_accept", 64'(acc2 - acc), 64'd5);
        drain();

        // Independent slot/module pairs stream concurrently.
        send(5'd1, 5'd0, 32'h0, 16'd16, acc, waited);
        send(5'd2, 5'd1, 32'h40, 16'd16, acc2, waited2);
        check("concurrent_accept", 64'(acc2 - acc), 64'd1);
        drain();

        // Reset in the middle of a count-10 transfer.
        send(5'd3, 5'd5, 32'h200, 16'd10, acc, waited);
        while (cyc < acc + 3) @(negedge clk);
        rst = 1'b1;
        flush_queues();
        @(negedge clk);
        check("rst_valid", 64'(module_in_valid), 64'd0);
        check("rst_last", 64'(module_in_last), 64'd0);
        check("rst_raddr3", 64'(ram_raddr[3]), 64'd0);
        check("rst_select5", 64'(slot_select[5]), 64'd0);
        check("rst_idle", 64'(idle), 64'd1);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        rst = 1'b0;
        send(5'd3, 5'd5, 32'h300, 16'd2, acc, waited);
        check("post_rst_accept_wait", 64'(waited), 64'd0);
        drain();

        // Random in-range traffic; scoreboard checks every address and beat.
        for (int i = 0; i < 10; i++) begin
            send(5'($urandom_range(0, SLOT_NUM - 1)), 5'($urandom_range(0, MODULE_NUM - 1)),
                 32'($urandom()), 16'($urandom_range(1, 6)), acc, waited);
        end
        drain();
        check("final_idle", 64'(idle), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
